// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the unified memory arbiter.
//   DefaultWordBitwidth : default address/data width
//   arb_state_e         : arbiter FSM state encoding
package riscv_pkg;

  localparam int unsigned DefaultWordBitwidth = 32;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StInstBusy = 2'd1,
    StDataBusy = 2'd2
  } arb_state_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: bundle of the instruction port, data port, shared memory port and
// error flag of the unified memory arbiter.
//   slave  : arbiter view (requests and mem response in, results and mem request out)
//   master : environment view (requesters plus memory), directions reversed
interface unified_mem_arbiter_if
  import riscv_pkg::*;
#(
  parameter int unsigned WORD_BITWIDTH = DefaultWordBitwidth
) ();

  logic                     inst_ce;
  logic [WORD_BITWIDTH-1:0] inst_addr;
  logic [WORD_BITWIDTH-1:0] inst_rdata;
  logic                     inst_valid;

  logic                     data_ce;
  logic                     data_we;
  logic [WORD_BITWIDTH-1:0] data_addr;
  logic [WORD_BITWIDTH-1:0] data_wdata;
  logic [WORD_BITWIDTH-1:0] data_rdata;
  logic                     data_valid;

  logic                     mem_req;
  logic                     mem_we;
  logic [WORD_BITWIDTH-1:0] mem_addr;
  logic [WORD_BITWIDTH-1:0] mem_wdata;
  logic [WORD_BITWIDTH-1:0] mem_rdata;
  logic                     mem_ack;

  logic                     err;

  modport slave (
    input  inst_ce, inst_addr,
    output inst_rdata, inst_valid,
    input  data_ce, data_we, data_addr, data_wdata,
    output data_rdata, data_valid,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output err
  );

  modport master (
    output inst_ce, inst_addr,
    input  inst_rdata, inst_valid,
    output data_ce, data_we, data_addr, data_wdata,
    input  data_rdata, data_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  err
  );

endinterface

// File: rtl/arb_timeout_counter.sv
// arb_timeout_counter: counts consecutive cycles with run high and flags the cycle in which
// the count reaches Limit. Clears whenever run is low.
//   clk     : clock
//   rst     : asynchronous active-low reset
//   run     : high while the arbiter is waiting on the memory
//   expired : high during the Limit-th consecutive run cycle
module arb_timeout_counter #(
  parameter int unsigned Limit = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = run ? cnt_q + CntW'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of run cycles already completed.
  assign expired = run && (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one memory port between an instruction-fetch requester and a
// data (load/store) requester.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-low reset
//   bus : unified_mem_arbiter_if.slave
//         inst_ce/inst_addr in, inst_rdata/inst_valid out (fetch)
//         data_ce/data_we/data_addr/data_wdata in, data_rdata/data_valid out (load/store)
//         mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in (memory)
//         err out (sticky watchdog flag)
// Build option: define ARB_TIMEOUT_EN to add the acknowledge watchdog (arb_timeout_counter);
// without it BUSY waits forever and err is tied low.
module unified_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned WORD_BITWIDTH  = DefaultWordBitwidth,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                 clk,
  input logic                 rst,
  unified_mem_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;

  logic [WORD_BITWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_BITWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                     mem_we_q, mem_we_d;
  logic [WORD_BITWIDTH-1:0] inst_rdata_q, inst_rdata_d;
  logic [WORD_BITWIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                     inst_valid_q, inst_valid_d;
  logic                     data_valid_q, data_valid_d;
  logic                     last_data_q, last_data_d;

  logic inst_elig, data_elig;
  logic grant_inst, grant_data;
  logic busy;
  logic timeout;

  // A requester still sees its own valid pulse while it drops ce, so mask it for that cycle.
  assign inst_elig  = bus.inst_ce && !inst_valid_q;
  assign data_elig  = bus.data_ce && !data_valid_q;
  assign grant_data = data_elig && (!inst_elig || !last_data_q);
  assign grant_inst = inst_elig && !grant_data;
  assign busy       = (state_q != StIdle);

`ifdef ARB_TIMEOUT_EN
  logic expired;
  logic err_q;

  arb_timeout_counter #(
    .Limit (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .run     (busy),
    .expired (expired)
  );

  // An ack in the limit cycle completes normally.
  assign timeout = expired && !bus.mem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | timeout;
    end
  end

  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_data) begin
          state_d = StDataBusy;
        end else if (grant_inst) begin
          state_d = StInstBusy;
        end
      end
      StInstBusy, StDataBusy: begin
        if (bus.mem_ack || timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    last_data_d  = last_data_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_valid_d = 1'b0;
    data_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_data) begin
          mem_addr_d  = bus.data_addr;
          mem_we_d    = bus.data_we;
          mem_wdata_d = bus.data_wdata;
          last_data_d = 1'b1;
        end else if (grant_inst) begin
          mem_addr_d  = bus.inst_addr;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          last_data_d = 1'b0;
        end
      end
      StInstBusy: begin
        if (bus.mem_ack) begin
          inst_rdata_d = bus.mem_rdata;
          inst_valid_d = 1'b1;
        end else if (timeout) begin
          inst_rdata_d = '0;
          inst_valid_d = 1'b1;
        end
      end
      StDataBusy: begin
        if (bus.mem_ack) begin
          if (!mem_we_q) begin
            data_rdata_d = bus.mem_rdata;
          end
          data_valid_d = 1'b1;
        end else if (timeout) begin
          data_rdata_d = '0;
          data_valid_d = 1'b1;
        end
      end
      default: ;
    endcase

    bus.mem_req    = busy;
    bus.mem_we     = mem_we_q;
    bus.mem_addr   = mem_addr_q;
    bus.mem_wdata  = mem_wdata_q;
    bus.inst_rdata = inst_rdata_q;
    bus.inst_valid = inst_valid_q;
    bus.data_rdata = data_rdata_q;
    bus.data_valid = data_valid_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      last_data_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      last_data_q  <= last_data_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_valid_q <= inst_valid_d;
      data_valid_q <= data_valid_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: randomized scoreboard bench for unified_mem_arbiter.
// Requester tasks push expected read data at issue time; a monitor pops on each valid pulse.
// A memory responder answers mem_req with programmable delay and logs every grant.
// Timeout scenarios are included when ARB_TIMEOUT_EN is defined.
module tb_unified_mem_arbiter;

  localparam int unsigned Wb            = 32;
  localparam int unsigned TimeoutCycles = 4;
  localparam int          WaitBound     = 300;
  localparam int          NumRandom     = 40;

  typedef struct {
    logic          we;
    logic [Wb-1:0] addr;
    logic [Wb-1:0] wdata;
  } grant_t;

  logic clk;
  logic rst;

  unified_mem_arbiter_if #(.WORD_BITWIDTH(Wb)) bus ();

  unified_mem_arbiter #(
    .WORD_BITWIDTH  (Wb),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  logic [Wb-1:0] inst_q[$];
  logic [Wb-1:0] data_q[$];
  grant_t        grant_log[$];
  logic [Wb-1:0] ref_mem[logic [Wb-1:0]];  // reference model view of memory
  logic [Wb-1:0] tb_mem[logic [Wb-1:0]];   // memory responder contents
  logic [Wb-1:0] last_load = '0;           // model of data_rdata
  int            fixed_delay = -1;         // <0: random ack delay 0..3
  int            dv_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [Wb-1:0] init_word(input logic [Wb-1:0] a);
    return (a << 7) ^ a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [Wb-1:0] ref_word(input logic [Wb-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [Wb-1:0] mem_word(input logic [Wb-1:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : init_word(a);
  endfunction

  // Memory responder: ack after wait_left extra busy cycles, check held request fields.
  initial begin : mem_responder
    int     wait_left;
    bit     serving;
    grant_t g;
    serving = 1'b0;
    wait_left = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        serving = 1'b0;
        bus.mem_ack = 1'b0;
        continue;
      end
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        serving = 1'b0;
      end else if (serving && !bus.mem_req) begin
        serving = 1'b0;  // aborted by the watchdog
      end
      if (bus.mem_req) begin
        if (!serving) begin
          serving = 1'b1;
          g.we = bus.mem_we;
          g.addr = bus.mem_addr;
          g.wdata = bus.mem_wdata;
          grant_log.push_back(g);
          wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
          if (g.addr < 32'h100) check("inst_grant_mem_we", 64'(bus.mem_we), 64'(0));
        end else begin
          check("held_addr", 64'(bus.mem_addr), 64'(g.addr));
          check("held_we_wdata", {31'b0, bus.mem_we, bus.mem_wdata}, {31'b0, g.we, g.wdata});
        end
        if (wait_left == 0) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = g.we ? $urandom : mem_word(g.addr);
          if (g.we) tb_mem[g.addr] = g.wdata;
        end else begin
          wait_left--;
          bus.mem_rdata = $urandom;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.inst_valid) begin
          if (inst_q.size() == 0) check("inst_spurious_valid", 64'(bus.inst_valid), 64'(0));
          else check("inst_rdata", 64'(bus.inst_rdata), 64'(inst_q.pop_front()));
        end
        if (bus.data_valid) begin
          dv_seen++;
          if (data_q.size() == 0) check("data_spurious_valid", 64'(bus.data_valid), 64'(0));
          else check("data_rdata", 64'(bus.data_rdata), 64'(data_q.pop_front()));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // All issue tasks start and end at posedge+1.
  task automatic issue_inst(input logic [Wb-1:0] addr, input bit aborted, input bit linger,
                            output int lat);
    int t = 0;
    bus.inst_ce = 1'b1;
    bus.inst_addr = addr;
    inst_q.push_back(aborted ? '0 : ref_word(addr));
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!bus.inst_valid && t < WaitBound);
    check("inst_done", 64'(bus.inst_valid), 64'(1));
    lat = t;
    if (linger) cycles(1);
    bus.inst_ce = 1'b0;
  endtask

  task automatic issue_data(input bit we, input logic [Wb-1:0] addr, input logic [Wb-1:0] wdata,
                            input bit linger, output int lat);
    int t = 0;
    bus.data_ce = 1'b1;
    bus.data_we = we;
    bus.data_addr = addr;
    bus.data_wdata = wdata;
    if (we) begin
      ref_mem[addr] = wdata;
      data_q.push_back(last_load);
    end else begin
      last_load = ref_word(addr);
      data_q.push_back(last_load);
    end
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!bus.data_valid && t < WaitBound);
    check("data_done", 64'(bus.data_valid), 64'(1));
    lat = t;
    if (linger) cycles(1);
    bus.data_ce = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.inst_ce = 1'b0;
    bus.data_ce = 1'b0;
    inst_q.delete();
    data_q.delete();
    last_load = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycles(1);
  endtask

  initial begin : main
    int lat;
    int lat2;
    int dv_before;
    rst = 1'b0;
    bus.inst_ce = 1'b0;
    bus.inst_addr = '0;
    bus.data_ce = 1'b0;
    bus.data_we = 1'b0;
    bus.data_addr = '0;
    bus.data_wdata = '0;
    tb_mem[32'h10] = 32'h00A0_0093;
    ref_mem[32'h10] = 32'h00A0_0093;

    // Reset state.
    #12;
    check("rst_mem_req", 64'(bus.mem_req), 64'(0));
    check("rst_mem_we", 64'(bus.mem_we), 64'(0));
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_valids", {bus.inst_valid, bus.data_valid}, 64'(0));
    check("rst_rdata", {bus.inst_rdata, bus.data_rdata}, 64'(0));
    check("rst_err", 64'(bus.err), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    cycles(1);

    // Single fetch, ack in second busy cycle.
    fixed_delay = 1;
    grant_log.delete();
    issue_inst(32'h10, 1'b0, 1'b0, lat);
    check("fetch_latency", 64'(lat), 64'(3));
    check("fetch_grants", 64'(grant_log.size()), 64'(1));
    cycles(1);

    // Minimum latency load.
    fixed_delay = 0;
    issue_data(1'b0, 32'h108, '0, 1'b0, lat);
    check("min_latency", 64'(lat), 64'(2));
    cycles(1);

    // Store leaves data_rdata unchanged, then read it back.
    fixed_delay = 2;
    grant_log.delete();
    issue_data(1'b1, 32'h100, 32'hCAFE_BABE, 1'b0, lat);
    check("store_grants", 64'(grant_log.size()), 64'(1));
    if (grant_log.size() > 0) begin
      check("store_mem_we", 64'(grant_log[0].we), 64'(1));
      check("store_mem_addr", 64'(grant_log[0].addr), 64'(32'h100));
      check("store_mem_wdata", 64'(grant_log[0].wdata), 64'(32'hCAFE_BABE));
    end
    cycles(1);
    issue_data(1'b0, 32'h100, '0, 1'b0, lat);
    cycles(1);

    // Contention from reset: data first, then inst.
    apply_reset();
    fixed_delay = 1;
    grant_log.delete();
    fork
      issue_inst(32'h20, 1'b0, 1'b0, lat);
      issue_data(1'b0, 32'h104, '0, 1'b0, lat2);
    join
    check("pair1_grants", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() >= 2) begin
      check("pair1_first_data", 64'(grant_log[0].addr), 64'(32'h104));
      check("pair1_second_inst", 64'(grant_log[1].addr), 64'(32'h20));
    end
    // After a data grant, a simultaneous pair goes to inst.
    cycles(1);
    issue_data(1'b0, 32'h10C, '0, 1'b0, lat);
    cycles(1);
    grant_log.delete();
    fork
      issue_inst(32'h24, 1'b0, 1'b0, lat);
      issue_data(1'b0, 32'h110, '0, 1'b0, lat2);
    join
    check("pair2_grants", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() >= 2) begin
      check("pair2_first_inst", 64'(grant_log[0].addr), 64'(32'h24));
      check("pair2_second_data", 64'(grant_log[1].addr), 64'(32'h110));
    end
    cycles(1);

    // Reset in the middle of a data access.
    fixed_delay = 1000;
    bus.data_ce = 1'b1;
    bus.data_we = 1'b0;
    bus.data_addr = 32'h10C;
    lat = 0;
    do begin
      cycles(1);
      lat++;
    end while (!bus.mem_req && lat < 10);
    check("midrst_req_up", 64'(bus.mem_req), 64'(1));
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.data_ce = 1'b0;
    inst_q.delete();
    data_q.delete();
    last_load = '0;
    #1;
    check("midrst_req_low", 64'(bus.mem_req), 64'(0));
    check("midrst_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("midrst_data_rdata", 64'(bus.data_rdata), 64'(0));
    dv_before = dv_seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycles(6);
    check("midrst_no_valid", 64'(dv_seen), 64'(dv_before));
    check("midrst_idle", 64'(bus.mem_req), 64'(0));

`ifdef ARB_TIMEOUT_EN
    // Ack in the limit cycle completes normally; no ack aborts with rdata 0 and sticky err.
    fixed_delay = int'(TimeoutCycles) - 1;
    issue_inst(32'h30, 1'b0, 1'b0, lat);
    check("to_ack_at_limit_lat", 64'(lat), 64'(TimeoutCycles + 1));
    check("to_ack_at_limit_err", 64'(bus.err), 64'(0));
    cycles(1);
    fixed_delay = 1000;
    issue_inst(32'h34, 1'b1, 1'b0, lat);
    check("to_abort_lat", 64'(lat), 64'(TimeoutCycles + 1));
    check("to_abort_err", 64'(bus.err), 64'(1));
    cycles(1);
    fixed_delay = 0;
    issue_inst(32'h38, 1'b0, 1'b0, lat);
    check("to_err_sticky", 64'(bus.err), 64'(1));
    apply_reset();
    check("to_err_cleared", 64'(bus.err), 64'(0));
`endif

    // Randomized traffic from both requesters.
    fixed_delay = -1;
    fork
      begin
        int l;
        for (int i = 0; i < NumRandom; i++) begin
          cycles($urandom_range(0, 2));
          issue_inst({$urandom_range(0, 63), 2'b00}, 1'b0, 1'($urandom_range(0, 1)), l);
        end
      end
      begin
        int l;
        for (int i = 0; i < NumRandom; i++) begin
          cycles($urandom_range(0, 2));
          issue_data(1'($urandom_range(0, 1)), 32'h100 + {$urandom_range(0, 15), 2'b00},
                     $urandom, 1'($urandom_range(0, 1)), l);
        end
      end
    join
    cycles(5);
    check("inst_queue_drained", 64'(inst_q.size()), 64'(0));
    check("data_queue_drained", 64'(data_q.size()), 64'(0));
    check("final_err", 64'(bus.err), 64'(0));
    check("final_idle", 64'(bus.mem_req), 64'(0));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
